// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline sequencer.
//   pipe_state_t   : sequencer FSM states
//   DEFAULT_HLT_OP : default halt opcode
//   WAIT_W/STALL_W : widths of the data-memory watchdog and stall counters
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALT      = 2'd2
    } pipe_state_t;

    localparam logic [3:0]  DEFAULT_HLT_OP = 4'hF;
    localparam int unsigned WAIT_W         = 8;
    localparam int unsigned STALL_W        = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard compare.
//   idex_MemRead, idex_RegRd      : load in ID/EX and its destination
//   ifid_RegRs/Rt, ifid_uses_rs/rt: sources read by the IF/ID instruction
//   loadUse                       : the IF/ID instruction needs the load result
module hazard_detect (
    input  logic       idex_MemRead,
    input  logic [3:0] idex_RegRd,
    input  logic [3:0] ifid_RegRs,
    input  logic [3:0] ifid_RegRt,
    input  logic       ifid_uses_rs,
    input  logic       ifid_uses_rt,
    output logic       loadUse
);

    logic rsHit;
    logic rtHit;

    always_comb begin
        rsHit   = ifid_uses_rs && (ifid_RegRs == idex_RegRd);
        rtHit   = ifid_uses_rt && (ifid_RegRt == idex_RegRd);
        // r0 is hard-wired zero, so a load targeting it never creates a dependency
        loadUse = idex_MemRead && (idex_RegRd != 4'd0) && (rsHit || rtHit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 16-bit five-stage CPU.
// Inputs : IF/ID, ID/EX, EX/MEM and MEM/WB control fields, imem_ready, dmem_ready.
// Outputs: per-stage write enables and flushes, PC branch select, dmem_req
//          (combinational); halted, timeout_err, stall_cycles (registered).
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 255,
    parameter logic [3:0]  HLT_OP       = DEFAULT_HLT_OP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         ifid_Opcode,
    input  logic [3:0]         ifid_RegRs,
    input  logic [3:0]         ifid_RegRt,
    input  logic               ifid_uses_rs,
    input  logic               ifid_uses_rt,
    input  logic               idex_MemRead,
    input  logic [3:0]         idex_RegRd,
    input  logic               exmem_Branch,
    input  logic               exmem_taken,
    input  logic               exmem_MemRead,
    input  logic               exmem_MemWrite,
    input  logic [3:0]         memwb_Opcode,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               pc_wen,
    output logic               pc_sel_branch,
    output logic               ifid_wen,
    output logic               ifid_flush,
    output logic               idex_wen,
    output logic               idex_flush,
    output logic               exmem_wen,
    output logic               exmem_flush,
    output logic               memwb_wen,
    output logic               dmem_req,
    output logic               halted,
    output logic               timeout_err,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(DMEM_TIMEOUT);

    pipe_state_t        state;
    pipe_state_t        nextState;
    logic [WAIT_W-1:0]  waitCnt;
    logic [WAIT_W-1:0]  waitNext;
    logic               timeoutFire;
    logic               advance;
    logic               memOp;
    logic               branchTaken;
    logic               loadUse;

    // Front-end decisions used whenever the pipeline is allowed to advance
    logic fPcWen;
    logic fSel;
    logic fIfidWen;
    logic fIfidFlush;
    logic fIdexFlush;
    logic fExmemFlush;

    hazard_detect u_hazard (
        .idex_MemRead (idex_MemRead),
        .idex_RegRd   (idex_RegRd),
        .ifid_RegRs   (ifid_RegRs),
        .ifid_RegRt   (ifid_RegRt),
        .ifid_uses_rs (ifid_uses_rs),
        .ifid_uses_rt (ifid_uses_rt),
        .loadUse      (loadUse)
    );

    assign memOp       = exmem_MemRead || exmem_MemWrite;
    assign branchTaken = exmem_Branch && exmem_taken;
    assign waitNext    = waitCnt + WAIT_W'(1);

    always_comb begin
        fPcWen      = 1'b1;
        fSel        = 1'b0;
        fIfidWen    = 1'b1;
        fIfidFlush  = 1'b0;
        fIdexFlush  = 1'b0;
        fExmemFlush = 1'b0;
        if (branchTaken) begin
            // The squash also kills any younger load-use or fetch stall
            fSel        = 1'b1;
            fIfidFlush  = 1'b1;
            fIdexFlush  = 1'b1;
            fExmemFlush = 1'b1;
        end else begin
            if (loadUse) begin
                fPcWen     = 1'b0;
                fIfidWen   = 1'b0;
                fIdexFlush = 1'b1;
            end
            // Holding IF/ID for a load-use wins over bubbling it for a fetch wait
            if (!imem_ready) begin
                fPcWen = 1'b0;
                if (!loadUse) fIfidFlush = 1'b1;
            end
            if (ifid_Opcode == HLT_OP) fPcWen = 1'b0;
        end
    end

    always_comb begin
        nextState     = state;
        timeoutFire   = 1'b0;
        advance       = 1'b0;
        pc_wen        = 1'b0;
        pc_sel_branch = 1'b0;
        ifid_wen      = 1'b0;
        ifid_flush    = 1'b0;
        idex_wen      = 1'b0;
        idex_flush    = 1'b0;
        exmem_wen     = 1'b0;
        exmem_flush   = 1'b0;
        memwb_wen     = 1'b0;
        dmem_req      = 1'b0;

        case (state)
            RUN: begin
                if (memwb_Opcode == HLT_OP) begin
                    nextState = HALT;
                end else if (memOp && !dmem_ready) begin
                    dmem_req  = 1'b1;
                    nextState = DMEM_WAIT;
                end else begin
                    dmem_req = memOp;
                    advance  = 1'b1;
                end
            end
            DMEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    advance   = 1'b1;
                    nextState = RUN;
                end else if (waitNext == TIMEOUT_V) begin
                    timeoutFire = 1'b1;
                    nextState   = HALT;
                end
            end
            HALT: begin
            end
            default: nextState = RUN;
        endcase

        if (advance) begin
            pc_wen        = fPcWen;
            pc_sel_branch = fSel;
            ifid_wen      = fIfidWen;
            ifid_flush    = fIfidFlush;
            idex_wen      = 1'b1;
            idex_flush    = fIdexFlush;
            exmem_wen     = 1'b1;
            exmem_flush   = fExmemFlush;
            memwb_wen     = 1'b1;
        end

        if (rst) begin
            pc_wen        = 1'b0;
            pc_sel_branch = 1'b0;
            ifid_wen      = 1'b0;
            ifid_flush    = 1'b0;
            idex_wen      = 1'b0;
            idex_flush    = 1'b0;
            exmem_wen     = 1'b0;
            exmem_flush   = 1'b0;
            memwb_wen     = 1'b0;
            dmem_req      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            waitCnt      <= '0;
            stall_cycles <= '0;
            halted       <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= nextState;
            if (state != DMEM_WAIT && nextState == DMEM_WAIT) begin
                waitCnt <= '0;
            end else if (state == DMEM_WAIT && !dmem_ready) begin
                waitCnt <= waitNext;
            end
            if (nextState == HALT) halted <= 1'b1;
            if (timeoutFire) timeout_err <= 1'b1;
            if (state != HALT && !pc_wen && !pc_sel_branch && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int unsigned TO = 4;
    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_HALT = 2;

    typedef struct packed {
        logic [3:0] ifOp;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic       idMR;
        logic [3:0] idRd;
        logic       br;
        logic       tk;
        logic       exMR;
        logic       exMW;
        logic [3:0] wbOp;
        logic       imr;
        logic       dmr;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ifid_Opcode, ifid_RegRs, ifid_RegRt, idex_RegRd, memwb_Opcode;
    logic        ifid_uses_rs, ifid_uses_rt, idex_MemRead;
    logic        exmem_Branch, exmem_taken, exmem_MemRead, exmem_MemWrite;
    logic        imem_ready, dmem_ready;
    logic        pc_wen, pc_sel_branch, ifid_wen, ifid_flush, idex_wen, idex_flush;
    logic        exmem_wen, exmem_flush, memwb_wen, dmem_req, halted, timeout_err;
    logic [15:0] stall_cycles;
    logic [9:0]  outs;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign outs = {pc_wen, pc_sel_branch, ifid_wen, ifid_flush, idex_wen, idex_flush,
                   exmem_wen, exmem_flush, memwb_wen, dmem_req};

    pipe_ctrl #(.DMEM_TIMEOUT(TO), .HLT_OP(4'hF)) dut (
        .clk(clk), .rst(rst),
        .ifid_Opcode(ifid_Opcode), .ifid_RegRs(ifid_RegRs), .ifid_RegRt(ifid_RegRt),
        .ifid_uses_rs(ifid_uses_rs), .ifid_uses_rt(ifid_uses_rt),
        .idex_MemRead(idex_MemRead), .idex_RegRd(idex_RegRd),
        .exmem_Branch(exmem_Branch), .exmem_taken(exmem_taken),
        .exmem_MemRead(exmem_MemRead), .exmem_MemWrite(exmem_MemWrite),
        .memwb_Opcode(memwb_Opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_wen(pc_wen), .pc_sel_branch(pc_sel_branch),
        .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_wen(idex_wen), .idex_flush(idex_flush),
        .exmem_wen(exmem_wen), .exmem_flush(exmem_flush),
        .memwb_wen(memwb_wen), .dmem_req(dmem_req),
        .halted(halted), .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    function automatic in_t idle();
        in_t v;
        v = '0;
        v.ifOp = 4'h1;
        v.imr = 1'b1;
        return v;
    endfunction

    task automatic drive(input in_t v);
        ifid_Opcode    = v.ifOp;
        ifid_RegRs     = v.rs;
        ifid_RegRt     = v.rt;
        ifid_uses_rs   = v.urs;
        ifid_uses_rt   = v.urt;
        idex_MemRead   = v.idMR;
        idex_RegRd     = v.idRd;
        exmem_Branch   = v.br;
        exmem_taken    = v.tk;
        exmem_MemRead  = v.exMR;
        exmem_MemWrite = v.exMW;
        memwb_Opcode   = v.wbOp;
        imem_ready     = v.imr;
        dmem_ready     = v.dmr;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(idle());
        tick();
        rst = 1'b0;
    endtask

    task automatic add(input string n, input in_t v, input logic [9:0] e);
        vec_t t;
        t.name = n;
        t.in = v;
        t.exp = e;
        tbl.push_back(t);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end

    initial begin
        in_t v;
        int mode, mWait, mStall;
        logic mHalted, mTo;

        drive(idle());

        // Output order: pc_wen sel ifid_wen ifid_flush idex_wen idex_flush exmem_wen exmem_flush memwb_wen dmem_req
        v = idle();                                                   add("idle", v, 10'b1010101010);
        v = idle(); v.idMR = 1; v.idRd = 3; v.rs = 3; v.urs = 1;      add("loaduse_rs", v, 10'b0000111010);
        v.idRd = 0; v.rs = 0;                                         add("loaduse_r0", v, 10'b1010101010);
        v = idle(); v.idMR = 1; v.idRd = 5; v.rt = 5;                 add("rt_unused", v, 10'b1010101010);
        v.urt = 1;                                                    add("loaduse_rt", v, 10'b0000111010);
        v = idle(); v.idRd = 5; v.rt = 5; v.urt = 1;                  add("no_load", v, 10'b1010101010);
        v = idle(); v.idMR = 1; v.idRd = 3; v.rs = 3; v.urs = 1; v.br = 1; v.tk = 1;
                                                                      add("branch_over_lu", v, 10'b1111111110);
        v = idle(); v.br = 1;                                         add("branch_not_taken", v, 10'b1010101010);
        v = idle(); v.imr = 0;                                        add("fetch_wait", v, 10'b0011101010);
        v = idle(); v.imr = 0; v.idMR = 1; v.idRd = 2; v.rt = 2; v.urt = 1;
                                                                      add("fetch_wait_lu", v, 10'b0000111010);
        v = idle(); v.imr = 0; v.br = 1; v.tk = 1;                    add("fetch_wait_branch", v, 10'b1111111110);
        v = idle(); v.ifOp = 4'hF;                                    add("hlt_decode", v, 10'b0010101010);
        v = idle(); v.exMR = 1; v.dmr = 1;                            add("mem_ready", v, 10'b1010101011);
        v = idle(); v.exMW = 1;                                       add("mem_not_ready", v, 10'b0000000001);
        v = idle(); v.wbOp = 4'hF;                                    add("hlt_retire", v, 10'b0000000000);
        v = idle(); v.wbOp = 4'hF; v.exMR = 1;                        add("hlt_over_mem", v, 10'b0000000000);
        v = idle(); v.exMR = 1; v.dmr = 1; v.br = 1; v.tk = 1;        add("mem_branch", v, 10'b1111111111);
        v = idle(); v.exMR = 1; v.dmr = 1; v.idMR = 1; v.idRd = 7; v.rs = 7; v.urs = 1;
                                                                      add("mem_loaduse", v, 10'b0000111011);

        doReset();
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_timeout", 32'(timeout_err), 32'd0);
        chk("reset_stall", 32'(stall_cycles), 32'd0);
        rst = 1'b1; #1;
        chk("outs_in_rst", 32'(outs), 32'd0);
        tick(); rst = 1'b0;

        foreach (tbl[i]) begin
            doReset();
            drive(tbl[i].in);
            #1;
            chk(tbl[i].name, 32'(outs), 32'(tbl[i].exp));
        end

        // Branch with a load-use present does not count as a stall
        doReset();
        v = idle(); v.idMR = 1; v.idRd = 3; v.rs = 3; v.urs = 1; v.br = 1; v.tk = 1;
        drive(v); tick(); drive(idle()); #1;
        chk("branch_stall_unchanged", 32'(stall_cycles), 32'd0);

        // Multi-cycle data memory: ready low for three cycles
        doReset();
        v = idle(); v.exMR = 1; drive(v); #1;
        chk("mc_run", 32'(outs), 32'(10'b0000000001));
        tick(); chk("mc_wait1", 32'(outs), 32'(10'b0000000001));
        tick(); chk("mc_wait2", 32'(outs), 32'(10'b0000000001));
        tick(); v.dmr = 1; drive(v); #1;
        chk("mc_done", 32'(outs), 32'(10'b1010101011));
        tick(); drive(idle()); #1;
        chk("mc_req_drop", 32'(outs), 32'(10'b1010101010));
        chk("mc_stall3", 32'(stall_cycles), 32'd3);

        // Watchdog with DMEM_TIMEOUT=4
        doReset();
        v = idle(); v.exMR = 1; drive(v); #1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wd_waiting", 32'(outs), 32'(10'b0000000001));
            chk("wd_no_err", 32'(timeout_err), 32'd0);
        end
        tick();
        chk("wd_err", 32'(timeout_err), 32'd1);
        chk("wd_halted", 32'(halted), 32'd1);
        chk("wd_outs", 32'(outs), 32'd0);
        v.dmr = 1; drive(v);
        repeat (3) tick();
        chk("wd_err_sticky", 32'(timeout_err), 32'd1);
        chk("wd_halt_sticky", 32'(halted), 32'd1);
        doReset();
        chk("wd_err_cleared", 32'(timeout_err), 32'd0);

        // HLT retirement
        doReset();
        v = idle(); v.wbOp = 4'hF; drive(v); #1;
        chk("hlt_pre_halted", 32'(halted), 32'd0);
        tick(); drive(idle()); #1;
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_outs", 32'(outs), 32'd0);
        tick(); tick();
        chk("hlt_outs_hold", 32'(outs), 32'd0);

        // Fetch wait for two cycles
        doReset();
        v = idle(); v.imr = 0; drive(v); #1;
        chk("fw_1", 32'(outs), 32'(10'b0011101010));
        tick(); chk("fw_2", 32'(outs), 32'(10'b0011101010));
        tick(); drive(idle()); #1;
        chk("fw_stall2", 32'(stall_cycles), 32'd2);

        // Reset in the middle of DMEM_WAIT
        doReset();
        v = idle(); v.exMR = 1; drive(v); tick();
        chk("rw_waiting", 32'(outs), 32'(10'b0000000001));
        rst = 1'b1; #1;
        chk("rw_req_drop", 32'(outs), 32'd0);
        tick(); rst = 1'b0; drive(idle()); #1;
        chk("rw_run", 32'(outs), 32'(10'b1010101010));
        chk("rw_stall0", 32'(stall_cycles), 32'd0);
        chk("rw_halted0", 32'(halted), 32'd0);

        // Randomized run against a rule-level model
        doReset();
        mode = M_RUN; mWait = 0; mStall = 0; mHalted = 0; mTo = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r, memOp, hazard, brT, stuck;
            logic [9:0] e;
            int nMode;
            tick();
            r = ($urandom_range(0, 39) == 0);
            v.ifOp = ($urandom_range(0, 11) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            v.rs   = 4'($urandom_range(0, 3));
            v.rt   = 4'($urandom_range(0, 3));
            v.urs  = 1'($urandom);
            v.urt  = 1'($urandom);
            v.idMR = 1'($urandom);
            v.idRd = 4'($urandom_range(0, 3));
            v.br   = 1'($urandom);
            v.tk   = 1'($urandom);
            v.exMR = ($urandom_range(0, 4) == 0);
            v.exMW = ($urandom_range(0, 4) == 0);
            v.wbOp = ($urandom_range(0, 59) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            v.imr  = ($urandom_range(0, 3) != 0);
            v.dmr  = 1'($urandom);
            rst = r;
            drive(v);
            #1;

            memOp  = v.exMR | v.exMW;
            hazard = v.idMR && v.idRd != 0 && ((v.urs && v.rs == v.idRd) || (v.urt && v.rt == v.idRd));
            brT    = v.br && v.tk;
            stuck  = !v.dmr && (mode == M_WAIT || memOp);
            e = '0;
            nMode = mode;
            if (r || mode == M_HALT) begin
                e = '0;
            end else if (mode == M_RUN && v.wbOp == 4'hF) begin
                nMode = M_HALT;
            end else if (stuck) begin
                e[0] = 1'b1;
            end else begin
                // {pc_wen, sel, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, exmem_flush, memwb_wen, req}
                e[0] = memOp || mode == M_WAIT;
                e[5] = 1'b1; e[3] = 1'b1; e[1] = 1'b1;
                if (brT) begin
                    e[9] = 1; e[8] = 1; e[7] = 1; e[6] = 1; e[4] = 1; e[2] = 1;
                end else begin
                    e[9] = !hazard && v.imr && v.ifOp != 4'hF;
                    e[7] = !hazard;
                    e[6] = !v.imr && !hazard;
                    e[4] = hazard;
                end
                nMode = M_RUN;
            end
            chk("rnd_outs", 32'(outs), 32'(e));
            chk("rnd_halted", 32'(halted), 32'(mHalted));
            chk("rnd_timeout", 32'(timeout_err), 32'(mTo));
            chk("rnd_stall", 32'(stall_cycles), 32'(mStall));

            if (r) begin
                mode = M_RUN; mWait = 0; mStall = 0; mHalted = 0; mTo = 0;
            end else begin
                if (mode != M_HALT && !e[9] && !e[8] && mStall < 65535) mStall++;
                if (stuck && mode == M_RUN && nMode != M_HALT) begin
                    nMode = M_WAIT; mWait = 0;
                end else if (stuck && mode == M_WAIT) begin
                    mWait++;
                    if (mWait == TO) begin
                        nMode = M_HALT; mTo = 1;
                    end
                end
                if (nMode == M_HALT) mHalted = 1;
                mode = nMode;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
